// File: rtl/net_tx_arbiter.sv
// Round-robin arbiter sharing one NI transmit port among NUM_REQ requesters.
// One registered output slot; flits addressed to this GPU are dropped and counted.
module net_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GPU_ID  = 12,
  parameter int CNT_W   = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [15:0]            net_data_out,
  output logic                   net_valid_out,
  input  logic                   net_ready_in,
  output logic [2:0]             grant_id,
  output logic [CNT_W-1:0]       tx_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam logic [5:0] OWN_ID = 6'(GPU_ID);
  localparam logic [2:0] LAST   = 3'(NUM_REQ - 1);

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e           state_q, state_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [15:0]      data_q, data_d;
  logic [2:0]       gid_q, gid_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic        lo_hit, hi_hit;
  logic [2:0]  lo_idx, hi_idx, win;
  logic [15:0] win_data;
  logic        slot_free, accept, drop, deliver;

  // Lowest valid at or above rr_ptr wins; otherwise wrap to lowest valid.
  always_comb begin
    lo_hit = 1'b0;
    hi_hit = 1'b0;
    lo_idx = '0;
    hi_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        lo_hit = 1'b1;
        lo_idx = 3'(k);
        if (3'(k) >= rr_ptr_q) begin
          hi_hit = 1'b1;
          hi_idx = 3'(k);
        end
      end
    end
    win = hi_hit ? hi_idx : lo_idx;
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (3'(k) == win) win_data = req_data[16*k +: 16];
    end
  end

  assign slot_free = (state_q == S_EMPTY) || net_ready_in;
  assign accept    = lo_hit && slot_free && ARESETn;
  assign drop      = accept && (win_data[15:10] == OWN_ID);
  assign deliver   = (state_q == S_FULL) && net_ready_in;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = accept && (3'(k) == win);
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    data_d     = data_q;
    gid_d      = gid_q;
    tx_cnt_d   = tx_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (deliver) begin
      state_d  = S_EMPTY;
      tx_cnt_d = tx_cnt_q + CNT_W'(1);
    end
    if (accept) begin
      rr_ptr_d = (win == LAST) ? 3'd0 : win + 3'd1;
      if (drop) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end else begin
        state_d = S_FULL;
        data_d  = win_data;
        gid_d   = win;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= S_EMPTY;
      rr_ptr_q   <= '0;
      data_q     <= '0;
      gid_q      <= '0;
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      data_q     <= data_d;
      gid_q      <= gid_d;
      tx_cnt_q   <= tx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign net_valid_out = (state_q == S_FULL);
  assign net_data_out  = data_q;
  assign grant_id      = gid_q;
  assign tx_cnt        = tx_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
